hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core. Drives the execute-stage forwarding
//  selects, detects load-use hazards, squashes wrong-path instructions on taken branches, and
//  sequences a multi-cycle multiply/divide unit (MDU) in EX by holding the front of the pipe.
//  Sits beside the F/D/E/M/W stage registers; all stall/flush outputs feed those registers.
// PARAMETERS
//  MDU_LATENCY  4  EX cycles an MDU op occupies (legal range 2..16)
//  REG_W        5  register index width
// PORTS
//  clk             in   1      core clock; all state updates on rising edge
//  reset           in   1      synchronous, active-high
//  id_rs, id_rt    in   REG_W  source regs of instruction in D
//  ex_rs, ex_rt    in   REG_W  source regs of instruction in E
//  ex_write_reg    in   REG_W  destination of instruction in E
//  ex_mem_to_reg   in   1      instruction in E is a load
//  ex_mdu_start    in   1      instruction in E is an MDU op (level, held while in E)
//  mem_write_reg   in   REG_W  destination in M;  mem_reg_write in 1: M writes reg
//  wb_write_reg    in   REG_W  destination in W;  wb_reg_write  in 1: W writes reg
//  mem_branch_taken in  1      branch in M resolved taken
//  forward_a/_b    out  2      00 = rd1/rd2, 01 = W result, 10 = M aluout, 11 never driven
//  stall_f, stall_d, stall_e  out 1   hold PC / D-reg / E-reg
//  flush_d, flush_e           out 1   bubble D-reg / E-reg on next edge
//  mdu_busy, mdu_done         out 1   MDU FSM status
//  perf_lu_stall, perf_mdu_stall, perf_flush  out 32  event counters (see CONFIGURATION)
// BEHAVIOUR
//  - Forwarding (comb): forward_a = 10 if mem_reg_write && mem_write_reg!=0 && ==ex_rs;
//    else 01 if wb_reg_write && wb_write_reg!=0 && ==ex_rs; else 00. Same for forward_b/ex_rt.
//    M has priority over W. Register 0 is never forwarded.
//  - Load-use (comb): lu = ex_mem_to_reg && ex_write_reg!=0 && (==id_rs || ==id_rt)
//    -> stall_f=stall_d=flush_e=1 for exactly that cycle (one bubble).
//  - Branch: mem_branch_taken -> flush_d=flush_e=1, and all stalls forced 0 (squash wins
//    over load-use and MDU hold).
//  - MDU FSM (registered), states IDLE/BUSY/DONE:
//    IDLE: ex_mdu_start && !mem_branch_taken -> BUSY, cnt <= MDU_LATENCY-2.
//    BUSY: stall_f=stall_d=stall_e=1, mdu_busy=1; cnt==0 -> DONE else cnt--.
//    DONE: mdu_done=1 one cycle, no stall; E-reg advances -> IDLE. Start not re-armed in DONE.
//    Total EX occupancy = MDU_LATENCY cycles (BUSY for MDU_LATENCY-1, then DONE).
//    mem_branch_taken in BUSY/DONE -> IDLE immediately (older branch kills MDU op in E).
//    Load-use and MDU cannot coexist in E; if lu while BUSY, MDU hold dominates (flush_e=0).
//  - Reset: FSM->IDLE, cnt->0, counters->0; while reset=1 all stall/flush/mdu outputs 0
//    and forward_a/_b=00. Reset mid-MDU aborts op with no mdu_done pulse.
//  - Latency: forwarding/hazard outputs combinational (same cycle); FSM outputs from state.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: perf_lu_stall +1 per lu cycle, perf_mdu_stall +1 per BUSY
//   cycle, perf_flush +1 per mem_branch_taken cycle; 32-bit, wrap at 2^32-1 -> 0.
//  Undefined: counter logic not built, perf_* ports present and tied to 0.
// TESTING
//  1 add $3 in M writes r3, E reads rs=3 -> forward_a=10; same in W only -> 01; dest r0 -> 00.
//  2 M and W both write r5, E rt=5 -> forward_b=10 (M priority).
//  3 lw r4 in E, D uses rs=4 -> stall_f/stall_d/flush_e=1 one cycle, 0 next cycle.
//  4 ex_mdu_start, MDU_LATENCY=4 -> stalls high 3 cycles, mdu_done pulse cycle 4, then IDLE.
//  5 mem_branch_taken in 2nd BUSY cycle -> flush_d/flush_e=1, stalls 0, FSM IDLE, no mdu_done.
//  6 reset asserted mid-BUSY -> next cycle IDLE, outputs 0; with HAZARD_PERF_CNT_EN counters 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline stage registers and hazard_ctrl.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_write_reg;
    logic             ex_mem_to_reg;
    logic             ex_mdu_start;
    logic [REG_W-1:0] mem_write_reg;
    logic             mem_reg_write;
    logic [REG_W-1:0] wb_write_reg;
    logic             wb_reg_write;
    logic             mem_branch_taken;

    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             flush_d;
    logic             flush_e;
    logic             mdu_busy;
    logic             mdu_done;
    logic [31:0]      perf_lu_stall;
    logic [31:0]      perf_mdu_stall;
    logic [31:0]      perf_flush;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, ex_mem_to_reg, ex_mdu_start,
               mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write, mem_branch_taken,
        input  forward_a, forward_b, stall_f, stall_d, stall_e, flush_d, flush_e,
               mdu_busy, mdu_done, perf_lu_stall, perf_mdu_stall, perf_flush
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, ex_mem_to_reg, ex_mdu_start,
               mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write, mem_branch_taken,
        output forward_a, forward_b, stall_f, stall_d, stall_e, flush_d, flush_e,
               mdu_busy, mdu_done, perf_lu_stall, perf_mdu_stall, perf_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipe: forwarding, load-use, branch squash, MDU hold.
// Define HAZARD_PERF_CNT_EN to build the perf_* event counters; otherwise they read 0.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_W       = 5
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.slave  hz
);
    localparam logic [3:0] CntLoad = 4'(MDU_LATENCY - 2);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mdu_state_e;

    mdu_state_e state_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       lu;
    logic       squash;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             m_we,
        input logic [REG_W-1:0] m_reg,
        input logic             w_we,
        input logic [REG_W-1:0] w_reg
    );
        if (m_we && (m_reg != REG_W'(0)) && (m_reg == src)) begin
            return 2'b10;
        end else if (w_we && (w_reg != REG_W'(0)) && (w_reg == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign lu = hz.ex_mem_to_reg && (hz.ex_write_reg != REG_W'(0)) &&
                ((hz.ex_write_reg == hz.id_rs) || (hz.ex_write_reg == hz.id_rt));
    assign squash = hz.mem_branch_taken;

    // MDU sequencer; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hz.ex_mdu_start && !squash) begin
                        state_q <= StBusy;
                        cnt_q   <= CntLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StBusy: begin
                    if (squash) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Priority: reset silences everything, then squash, then MDU hold, then load-use.
    always_comb begin
        hz.forward_a = 2'b00;
        hz.forward_b = 2'b00;
        hz.stall_f   = 1'b0;
        hz.stall_d   = 1'b0;
        hz.stall_e   = 1'b0;
        hz.flush_d   = 1'b0;
        hz.flush_e   = 1'b0;
        if (!reset) begin
            hz.forward_a = fwd_sel(hz.ex_rs, hz.mem_reg_write, hz.mem_write_reg,
                                   hz.wb_reg_write, hz.wb_write_reg);
            hz.forward_b = fwd_sel(hz.ex_rt, hz.mem_reg_write, hz.mem_write_reg,
                                   hz.wb_reg_write, hz.wb_write_reg);
            if (squash) begin
                hz.flush_d = 1'b1;
                hz.flush_e = 1'b1;
            end else if (busy_q) begin
                hz.stall_f = 1'b1;
                hz.stall_d = 1'b1;
                hz.stall_e = 1'b1;
            end else if (lu) begin
                hz.stall_f = 1'b1;
                hz.stall_d = 1'b1;
                hz.flush_e = 1'b1;
            end
        end
    end

    assign hz.mdu_busy = busy_q && !reset;
    assign hz.mdu_done = done_q && !reset;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q;
    logic [31:0] perf_mdu_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_q    <= '0;
            perf_mdu_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            if (lu)     perf_lu_q    <= perf_lu_q + 32'd1;
            if (busy_q) perf_mdu_q   <= perf_mdu_q + 32'd1;
            if (squash) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign hz.perf_lu_stall  = perf_lu_q;
    assign hz.perf_mdu_stall = perf_mdu_q;
    assign hz.perf_flush     = perf_flush_q;
`else
    assign hz.perf_lu_stall  = '0;
    assign hz.perf_mdu_stall = '0;
    assign hz.perf_flush     = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed spec scenarios followed by random traffic, all outputs
// compared every cycle against a cycle-count reference model of the hazard rules.
module tb_hazard_ctrl;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5)) hz ();

    hazard_ctrl #(.MDU_LATENCY(LAT), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: MDU tracked as "BUSY cycles still to go" plus a done flag.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    int unsigned pc_lu = 0;
    int unsigned pc_mdu = 0;
    int unsigned pc_fl = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if (hz.mem_reg_write && hz.mem_write_reg != 5'd0 && hz.mem_write_reg == src) return 2'b10;
        if (hz.wb_reg_write && hz.wb_write_reg != 5'd0 && hz.wb_write_reg == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        hz.id_rs = '0; hz.id_rt = '0; hz.ex_rs = '0; hz.ex_rt = '0;
        hz.ex_write_reg = '0; hz.ex_mem_to_reg = 1'b0; hz.ex_mdu_start = 1'b0;
        hz.mem_write_reg = '0; hz.mem_reg_write = 1'b0;
        hz.wb_write_reg = '0; hz.wb_reg_write = 1'b0; hz.mem_branch_taken = 1'b0;
    endtask

    // Check every output for the current inputs, then clock and advance the model.
    task automatic tick();
        bit lu, sq, hold, lu_eff;
        #2;
        lu = hz.ex_mem_to_reg && hz.ex_write_reg != 5'd0 &&
             (hz.ex_write_reg == hz.id_rs || hz.ex_write_reg == hz.id_rt);
        sq     = !reset && hz.mem_branch_taken;
        hold   = !reset && !sq && m_busy;
        lu_eff = !reset && !sq && !m_busy && lu;
        chk("forward_a", 32'(hz.forward_a), reset ? 32'd0 : 32'(fwd_exp(hz.ex_rs)));
        chk("forward_b", 32'(hz.forward_b), reset ? 32'd0 : 32'(fwd_exp(hz.ex_rt)));
        chk("stall_f", 32'(hz.stall_f), 32'(hold || lu_eff));
        chk("stall_d", 32'(hz.stall_d), 32'(hold || lu_eff));
        chk("stall_e", 32'(hz.stall_e), 32'(hold));
        chk("flush_d", 32'(hz.flush_d), 32'(sq));
        chk("flush_e", 32'(hz.flush_e), 32'(sq || lu_eff));
        chk("mdu_busy", 32'(hz.mdu_busy), 32'(!reset && m_busy));
        chk("mdu_done", 32'(hz.mdu_done), 32'(!reset && m_done));
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu_stall", hz.perf_lu_stall, pc_lu);
        chk("perf_mdu_stall", hz.perf_mdu_stall, pc_mdu);
        chk("perf_flush", hz.perf_flush, pc_fl);
`else
        chk("perf_lu_stall", hz.perf_lu_stall, 32'd0);
        chk("perf_mdu_stall", hz.perf_mdu_stall, 32'd0);
        chk("perf_flush", hz.perf_flush, 32'd0);
`endif
        @(posedge clk);
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            pc_lu = 0; pc_mdu = 0; pc_fl = 0;
        end else begin
            if (lu) pc_lu++;
            if (m_busy) pc_mdu++;
            if (hz.mem_branch_taken) pc_fl++;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                if (hz.mem_branch_taken) begin
                    m_busy = 1'b0;
                end else if (m_left == 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_left--;
                end
            end else if (hz.ex_mdu_start && !hz.mem_branch_taken) begin
                m_busy = 1'b1;
                m_left = LAT - 1;
            end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset must silence outputs even with forwarding/hazard-triggering inputs.
        hz.mem_reg_write = 1'b1; hz.mem_write_reg = 5'd3; hz.ex_rs = 5'd3;
        hz.ex_mem_to_reg = 1'b1; hz.ex_write_reg = 5'd4; hz.id_rs = 5'd4;
        hz.mem_branch_taken = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();

        // Forwarding: M hit, W-only hit, r0 destination, M over W priority.
        hz.mem_reg_write = 1'b1; hz.mem_write_reg = 5'd3; hz.ex_rs = 5'd3;
        tick();
        clear_inputs();
        hz.wb_reg_write = 1'b1; hz.wb_write_reg = 5'd3; hz.ex_rs = 5'd3;
        tick();
        clear_inputs();
        hz.mem_reg_write = 1'b1; hz.wb_reg_write = 1'b1; hz.ex_rs = 5'd0;
        tick();
        clear_inputs();
        hz.mem_reg_write = 1'b1; hz.mem_write_reg = 5'd5;
        hz.wb_reg_write = 1'b1; hz.wb_write_reg = 5'd5; hz.ex_rt = 5'd5;
        tick();
        chk("m_priority", 32'(hz.forward_b), 32'd2);

        // Load-use: one bubble, gone the next cycle.
        clear_inputs();
        hz.ex_mem_to_reg = 1'b1; hz.ex_write_reg = 5'd4; hz.id_rs = 5'd4;
        tick();
        clear_inputs();
        tick();

        // Full MDU op with start held through DONE (must not re-arm).
        hz.ex_mdu_start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        hz.ex_mdu_start = 1'b0;
        tick();
        tick();

        // Branch in second BUSY cycle kills the op.
        hz.ex_mdu_start = 1'b1;
        tick();
        tick();
        hz.mem_branch_taken = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();

        // Load-use while BUSY: hold dominates.
        hz.ex_mdu_start = 1'b1;
        tick();
        hz.ex_mdu_start = 1'b0;
        hz.ex_mem_to_reg = 1'b1; hz.ex_write_reg = 5'd7; hz.id_rt = 5'd7;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-BUSY aborts without a done pulse.
        hz.ex_mdu_start = 1'b1;
        tick();
        hz.ex_mdu_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Random traffic with small register indices so matches are frequent.
        for (int i = 0; i < 600; i++) begin
            hz.id_rs = 5'($urandom_range(0, 7));
            hz.id_rt = 5'($urandom_range(0, 7));
            hz.ex_rs = 5'($urandom_range(0, 7));
            hz.ex_rt = 5'($urandom_range(0, 7));
            hz.ex_write_reg = 5'($urandom_range(0, 7));
            hz.ex_mem_to_reg = ($urandom_range(0, 3) == 0);
            hz.ex_mdu_start = ($urandom_range(0, 3) == 0);
            hz.mem_write_reg = 5'($urandom_range(0, 7));
            hz.mem_reg_write = $urandom_range(0, 1) != 0;
            hz.wb_write_reg = 5'($urandom_range(0, 7));
            hz.wb_reg_write = $urandom_range(0, 1) != 0;
            hz.mem_branch_taken = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
